// File: rtl/spectrum_pulse_accumulator_if.sv
// spectrum_pulse_accumulator_if: shot/sample input, drain stream and status bundle of the pulse accumulator
interface spectrum_pulse_accumulator_if #(
    parameter int DIN_W = 32,
    parameter int ACC_W = 48,
    parameter int AW = 11
);
    logic start_i;
    logic [15:0] nacc_i;
    logic [AW:0] npts_i;
    logic [DIN_W-1:0] din_i;
    logic din_valid_i;
    logic [ACC_W-1:0] dout_o;
    logic dout_valid_o;
    logic dout_ready_i;
    logic dout_last_o;
    logic busy_o;
    logic overflow_o;
    logic frame_err_o;
    logic drop_o;
    modport slave (
        input start_i, nacc_i, npts_i, din_i, din_valid_i, dout_ready_i,
        output dout_o, dout_valid_o, dout_last_o, busy_o, overflow_o, frame_err_o, drop_o
    );
    modport master (
        output start_i, nacc_i, npts_i, din_i, din_valid_i, dout_ready_i,
        input dout_o, dout_valid_o, dout_last_o, busy_o, overflow_o, frame_err_o, drop_o
    );
endinterface

// File: rtl/spectrum_pulse_accumulator.sv
// spectrum_pulse_accumulator: sums nacc pulses of npts points in RAM, then drains the frame with valid/ready
module spectrum_pulse_accumulator #(
    parameter int DIN_W = 32,
    parameter int ACC_W = 48,
    parameter int NPTS_MAX = 2048,
    parameter int AW = $clog2(NPTS_MAX)
) (
    input logic clk_i,
    input logic rst_n_i,
    spectrum_pulse_accumulator_if.slave bus
);
    localparam logic [AW:0] NMAX = (AW+1)'(NPTS_MAX);
    typedef enum logic [1:0] {IDLE, ACC, WAIT, DRAIN} state_t;
    state_t state, state_nx;
    logic [ACC_W-1:0] mem [NPTS_MAX];
    logic [ACC_W-1:0] mem_q, byp_data, rdat, wdata, skid, dout;
    logic [ACC_W:0] sum;
    logic [DIN_W-1:0] wr_din;
    logic [15:0] nacc, nacc_clamp, nacc_eff, pulse_cnt, pulse_eff;
    logic [AW:0] npts, npts_clamp, npts_eff, rcnt;
    logic [AW-1:0] addr, addr_eff, raddr, wr_addr;
    logic [1:0] occ;
    logic open_pulse, take, last_pt, pop, rd_issue;
    logic wr_en, wr_first, byp, pend, pend_last, skid_v, skid_last;
    logic dout_valid, dout_last, overflow, frame_err;
    assign nacc_clamp = (bus.nacc_i == 16'd0) ? 16'd1 : bus.nacc_i;
    assign npts_clamp = (bus.npts_i == '0 || bus.npts_i > NMAX) ? NMAX : bus.npts_i;
    // State register
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) state <= IDLE;
        else state <= state_nx;
    end
    // Point acceptance, RAM port steering, saturating sum and next state; a start in IDLE/WAIT may carry point 0
    always_comb begin
        open_pulse = bus.start_i && (state == IDLE || state == WAIT);
        take = bus.din_valid_i && (state == ACC || open_pulse);
        addr_eff = (state == ACC) ? addr : '0;
        npts_eff = (state == IDLE) ? npts_clamp : npts;
        nacc_eff = (state == IDLE) ? nacc_clamp : nacc;
        pulse_eff = (state == IDLE) ? 16'd0 : pulse_cnt;
        last_pt = take && ({1'b0, addr_eff} == npts_eff - 1'b1);
        pop = dout_valid && bus.dout_ready_i;
        occ = 2'(dout_valid) + 2'(skid_v) + 2'(pend);
        rd_issue = (state == DRAIN) && (rcnt < npts) && (occ < 2'd2 || pop);
        raddr = (state == DRAIN) ? rcnt[AW-1:0] : addr_eff;
        rdat = byp ? byp_data : mem_q;
        sum = {1'b0, rdat} + (ACC_W+1)'(wr_din);
        wdata = wr_first ? ACC_W'(wr_din) : (sum[ACC_W] ? '1 : sum[ACC_W-1:0]);
        state_nx = state;
        if (open_pulse) state_nx = ACC;
        if (last_pt) state_nx = (pulse_eff + 16'd1 == nacc_eff) ? DRAIN : WAIT;
        if (state == DRAIN && pop && dout_last) state_nx = IDLE;
    end
    // Accumulation RAM: write lags the read by one cycle, read data registered
    always_ff @(posedge clk_i) begin
        if (wr_en) mem[wr_addr] <= wdata;
        mem_q <= mem[raddr];
    end
    // Frame control, write-back stage with same-address forwarding, and two-deep drain output buffer
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            nacc <= '0;
            npts <= '0;
            pulse_cnt <= '0;
            addr <= '0;
            rcnt <= '0;
            wr_en <= 1'b0;
            wr_addr <= '0;
            wr_din <= '0;
            wr_first <= 1'b0;
            byp <= 1'b0;
            byp_data <= '0;
            pend <= 1'b0;
            pend_last <= 1'b0;
            skid <= '0;
            skid_v <= 1'b0;
            skid_last <= 1'b0;
            dout <= '0;
            dout_valid <= 1'b0;
            dout_last <= 1'b0;
            overflow <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            wr_en <= take;
            wr_addr <= addr_eff;
            wr_din <= bus.din_i;
            wr_first <= pulse_eff == 16'd0;
            byp <= wr_en && wr_addr == raddr;
            byp_data <= wdata;
            if (state == IDLE && bus.start_i) begin
                nacc <= nacc_clamp;
                npts <= npts_clamp;
                pulse_cnt <= '0;
                overflow <= 1'b0;
                frame_err <= 1'b0;
            end
            if (open_pulse) addr <= '0;
            if (take) addr <= addr_eff + 1'b1;
            if (last_pt) pulse_cnt <= pulse_eff + 16'd1;
            if (wr_en && !wr_first && sum[ACC_W]) overflow <= 1'b1;
            if ((state == WAIT && bus.din_valid_i && !bus.start_i) || (state == ACC && bus.start_i)) frame_err <= 1'b1;
            rcnt <= (state == DRAIN) ? rcnt + (AW+1)'(rd_issue) : '0;
            pend <= rd_issue;
            pend_last <= rcnt == npts - 1'b1;
            if (!dout_valid || pop) begin
                dout_valid <= skid_v || pend;
                dout <= skid_v ? skid : (pend ? rdat : dout);
                dout_last <= skid_v ? skid_last : (pend && pend_last);
                skid_v <= skid_v && pend;
                if (skid_v && pend) begin
                    skid <= rdat;
                    skid_last <= pend_last;
                end
            end else if (pend) begin
                skid <= rdat;
                skid_v <= 1'b1;
                skid_last <= pend_last;
            end
        end
    end
    assign bus.dout_o = dout;
    assign bus.dout_valid_o = dout_valid;
    assign bus.dout_last_o = dout_last;
    assign bus.busy_o = state != IDLE;
    assign bus.overflow_o = overflow;
    assign bus.frame_err_o = frame_err;
    assign bus.drop_o = rst_n_i && state == DRAIN && bus.start_i;
endmodule

// File: tb/tb_spectrum_pulse_accumulator.sv
// tb_spectrum_pulse_accumulator: randomized frames against a frame-level sum model with a scoreboard monitor
module tb_spectrum_pulse_accumulator;
    localparam int DIN_W = 32;
    localparam int ACC_W = 33;
    localparam int NPTS_MAX = 64;
    localparam int AW = 6;
    localparam longint unsigned MAXV = (64'd1 << ACC_W) - 64'd1;
    typedef struct {
        longint unsigned d;
        bit l;
    } exp_t;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int vectors = 0;
    int miscompares = 0;
    bit bp = 1'b0;
    exp_t exp_q[$];
    longint unsigned dat [4][64];
    spectrum_pulse_accumulator_if #(.DIN_W(DIN_W), .ACC_W(ACC_W), .AW(AW)) bus ();
    spectrum_pulse_accumulator #(.DIN_W(DIN_W), .ACC_W(ACC_W), .NPTS_MAX(NPTS_MAX), .AW(AW)) dut (
        .clk_i(clk),
        .rst_n_i(rst_n),
        .bus(bus)
    );
    always #5 clk = ~clk;
    task automatic chk(input string name, input longint unsigned act, input longint unsigned expv);
        vectors++;
        if (act != expv) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask
    task automatic step;
        @(posedge clk);
        #1;
    endtask
    task automatic chk_all_zero(input string tag);
        chk({tag, "_dout"}, bus.dout_o, 0);
        chk({tag, "_dout_valid"}, bus.dout_valid_o, 0);
        chk({tag, "_dout_last"}, bus.dout_last_o, 0);
        chk({tag, "_busy"}, bus.busy_o, 0);
        chk({tag, "_overflow"}, bus.overflow_o, 0);
        chk({tag, "_frame_err"}, bus.frame_err_o, 0);
        chk({tag, "_drop"}, bus.drop_o, 0);
    endtask
    // mode: 0 random, 1 pattern 10*pulse+point, 2 all ones, 3 constant 5
    task automatic send_frame(input int nacc_in, input int npts_in, input int mode, input bit err, input bit drop_t);
        int na, np, i, k;
        bit ovf, injected;
        longint unsigned tot;
        na = (nacc_in == 0) ? 1 : nacc_in;
        np = (npts_in == 0 || npts_in > NPTS_MAX) ? NPTS_MAX : npts_in;
        for (int p = 0; p < na; p++)
            for (int j = 0; j < np; j++)
                dat[p][j] = (mode == 0) ? longint'($urandom) : (mode == 1) ? longint'(10 * p + j) :
                            (mode == 2) ? 64'hFFFF_FFFF : 64'd5;
        ovf = 1'b0;
        for (int j = 0; j < np; j++) begin
            tot = 0;
            for (int p = 0; p < na; p++) tot += dat[p][j];
            if (tot > MAXV) begin
                ovf = 1'b1;
                tot = MAXV;
            end
            exp_q.push_back(exp_t'{d: tot, l: (j == np - 1)});
        end
        injected = 1'b0;
        for (int p = 0; p < na; p++) begin
            if (p > 0 && err) begin
                bus.din_valid_i = 1'b1;
                bus.din_i = $urandom;
                step;
                bus.din_valid_i = 1'b0;
            end
            bus.start_i = 1'b1;
            bus.nacc_i = 16'(nacc_in);
            bus.npts_i = (AW+1)'(npts_in);
            i = 0;
            if (p == 0 && $urandom_range(0, 1) == 1) begin
                bus.din_valid_i = 1'b1;
                bus.din_i = 32'(dat[0][0]);
                i = 1;
            end
            step;
            bus.start_i = 1'b0;
            bus.din_valid_i = 1'b0;
            if (p == 0) begin
                chk("busy_rise", bus.busy_o, 1);
                chk("overflow_clear", bus.overflow_o, 0);
                chk("frame_err_clear", bus.frame_err_o, 0);
            end
            while (i < np) begin
                if (err && p == 0 && i == 2 && !injected) begin
                    bus.start_i = 1'b1;
                    injected = 1'b1;
                end else if ($urandom_range(0, 3) != 0) begin
                    bus.din_valid_i = 1'b1;
                    bus.din_i = 32'(dat[p][i]);
                    i++;
                end
                step;
                bus.start_i = 1'b0;
                bus.din_valid_i = 1'b0;
            end
        end
        if (drop_t) begin
            step;
            bus.start_i = 1'b1;
            @(negedge clk);
            chk("drop_pulse", bus.drop_o, 1);
            step;
            bus.start_i = 1'b0;
            @(negedge clk);
            chk("drop_idle", bus.drop_o, 0);
        end
        for (k = 0; k < 20000; k++) begin
            @(negedge clk);
            if (!bus.busy_o) break;
        end
        chk("frame_done", bus.busy_o, 0);
        chk("overflow", bus.overflow_o, longint'(ovf));
        chk("frame_err", bus.frame_err_o, longint'(err));
        chk("drained", exp_q.size(), 0);
        exp_q.delete();
        step;
    endtask
    // Downstream ready: constant high or random per cycle
    initial begin
        bus.dout_ready_i = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.dout_ready_i = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end
    // Monitor: pops the scoreboard on every transfer and checks stall stability
    initial begin : monitor
        bit stall;
        longint unsigned held;
        exp_t e;
        stall = 1'b0;
        held = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stall = 1'b0;
                continue;
            end
            if (stall) begin
                chk("stall_valid", bus.dout_valid_o, 1);
                chk("stall_data", bus.dout_o, held);
            end
            if (bus.dout_valid_o && bus.dout_ready_i) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_beat: got %0h expected no transfer at %0t", bus.dout_o, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("dout", bus.dout_o, e.d);
                    chk("dout_last", bus.dout_last_o, longint'(e.l));
                end
            end
            stall = bus.dout_valid_o && !bus.dout_ready_i;
            held = bus.dout_o;
        end
    end
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
    initial begin
        bus.start_i = 1'b0;
        bus.nacc_i = '0;
        bus.npts_i = '0;
        bus.din_i = '0;
        bus.din_valid_i = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        step;
        rst_n = 1'b1;
        step;
        send_frame(3, 8, 1, 0, 0);
        send_frame(3, 8, 2, 0, 0);
        send_frame(2, 8, 0, 0, 0);
        bp = 1'b1;
        send_frame(2, 16, 0, 0, 0);
        send_frame(3, 8, 0, 1, 1);
        bp = 1'b0;
        send_frame(0, 8, 0, 0, 0);
        send_frame(1, 0, 0, 0, 0);
        send_frame(1, 100, 0, 0, 0);
        bus.nacc_i = 16'd3;
        bus.npts_i = 7'd8;
        bus.start_i = 1'b1;
        bus.din_valid_i = 1'b1;
        bus.din_i = 32'd7;
        step;
        bus.start_i = 1'b0;
        repeat (3) begin
            bus.din_i = 32'd9;
            step;
        end
        bus.din_valid_i = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk_all_zero("midreset");
        step;
        send_frame(2, 4, 3, 0, 0);
        for (int r = 0; r < 4; r++) begin
            bp = 1'($urandom_range(0, 1));
            send_frame(int'($urandom_range(1, 4)), int'($urandom_range(1, 20)), 0, 0, 0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
